// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl
//   Round-based game sequencer. Each round it asks the random generator
//   for a target, spins the motor, then accepts keypad guesses until a
//   hit, the wrong-guess allowance is used up, or the key timer expires.
//   The hit/miss result is held for a fixed time. After ROUNDS rounds the
//   game ends and waits for a new start.
//
// Optional feature
//   GUESS_HINT_EN : when defined, every wrong guess updates the hint output
//                   (01 = target higher, 10 = target lower). The hint is
//                   cleared at the start of each round. When the macro is
//                   undefined, hint is tied to 00 and no comparator exists.
//
// Ports
//   clk         in   system clock
//   res         in   synchronous active-high reset
//   start       in   level; a rising edge starts or restarts a game
//   key_code    in   keypad code, qualified by key_valid
//   key_valid   in   one-cycle strobe per key press
//   rand_num    in   random value, sampled the cycle after rand_enable
//   motor_busy  in   motor is spinning
//   rand_enable out  one-cycle request for a new random value
//   motor_start out  one-cycle motor spin request
//   check       out  high while a hit result is displayed
//   miss        out  high while a miss result is displayed
//   score       out  hits in this game, saturating
//   round_num   out  current round, 0-based
//   tries_left  out  wrong guesses still allowed this round
//   game_over   out  high once all rounds have been played
//   hint        out  guess direction hint (see GUESS_HINT_EN)
//
// All outputs are registered.

module guess_game_ctrl #(
  parameter int KEY_W       = 4,
  parameter int ROUNDS      = 8,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 500000,
  parameter int RESULT_CYC  = 100000,
  parameter int SCORE_W     = 4
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           start,
  input  logic [KEY_W-1:0]               key_code,
  input  logic                           key_valid,
  input  logic [KEY_W-1:0]               rand_num,
  input  logic                           motor_busy,
  output logic                           rand_enable,
  output logic                           motor_start,
  output logic                           check,
  output logic                           miss,
  output logic [SCORE_W-1:0]             score,
  output logic [$clog2(ROUNDS+1)-1:0]    round_num,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           game_over,
  output logic [1:0]                     hint
);

  // state    | meaning
  // ---------+----------------------------------------------------------
  // S_IDLE   | after reset, waiting for a start edge
  // S_DRAW   | rand_enable pulse, tries reloaded, hint cleared
  // S_LATCH  | target captured from rand_num, motor_start pulse
  // S_SPIN   | at least two cycles, then until motor_busy drops
  // S_WAIT   | accepting guesses, key timer running
  // S_RESULT | check or miss held for RESULT_CYC cycles
  // S_OVER   | game finished, score and round frozen

  localparam int RW   = $clog2(ROUNDS + 1);
  localparam int TW   = $clog2(MAX_TRIES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam int RS_W = $clog2(RESULT_CYC + 1);

  localparam logic [RW-1:0]      LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [TW-1:0]      TRIES_INIT = TW'(MAX_TRIES);
  localparam logic [TO_W-1:0]    TO_LOAD    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RS_W-1:0]    RS_LOAD    = RS_W'(RESULT_CYC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_LATCH,
    S_SPIN,
    S_WAIT,
    S_RESULT,
    S_OVER
  } state_t;

  state_t state, state_nxt;

  logic                start_q;
  logic                start_edge;
  logic [KEY_W-1:0]    target, target_d;
  logic [TW-1:0]       tries_d;
  logic [SCORE_W-1:0]  score_d;
  logic [RW-1:0]       round_d;
  logic [TO_W-1:0]     to_cnt, to_cnt_d;
  logic [RS_W-1:0]     rs_cnt, rs_cnt_d;
  logic                spin_seen, spin_seen_d;
  logic                result_hit, hit_d;

`ifdef GUESS_HINT_EN
  logic [1:0]          hint_q, hint_d;
`endif

  assign start_edge = start & ~start_q;

  // Both timers are down-counters: loaded on entry, terminal count at zero.
  // The key timer's elapsed time is TO_LOAD - to_cnt.
  always_comb begin
    state_nxt   = state;
    target_d    = target;
    tries_d     = tries_left;
    score_d     = score;
    round_d     = round_num;
    to_cnt_d    = to_cnt;
    rs_cnt_d    = rs_cnt;
    spin_seen_d = spin_seen;
    hit_d       = result_hit;
`ifdef GUESS_HINT_EN
    hint_d      = hint_q;
`endif

    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt = S_DRAW;
          score_d   = '0;
          round_d   = '0;
        end
      end

      S_DRAW: begin
        state_nxt = S_LATCH;
      end

      S_LATCH: begin
        target_d    = rand_num;
        spin_seen_d = 1'b0;
        state_nxt   = S_SPIN;
      end

      S_SPIN: begin
        // spin_seen marks that the mandatory first cycle is done, so the
        // earliest exit is at the end of the second SPIN cycle.
        spin_seen_d = 1'b1;
        if (spin_seen && !motor_busy) begin
          state_nxt = S_WAIT;
          to_cnt_d  = TO_LOAD;
        end
      end

      S_WAIT: begin
        // A key arriving on the timeout cycle is still judged.
        if (key_valid) begin
          if (key_code == target) begin
            hit_d     = 1'b1;
            state_nxt = S_RESULT;
            rs_cnt_d  = RS_LOAD;
            if (score != SCORE_MAX) begin
              score_d = score + SCORE_W'(1);
            end
          end else begin
            tries_d  = tries_left - TW'(1);
            to_cnt_d = TO_LOAD;
`ifdef GUESS_HINT_EN
            hint_d   = (target > key_code) ? 2'b01 : 2'b10;
`endif
            if (tries_left == TW'(1)) begin
              hit_d     = 1'b0;
              state_nxt = S_RESULT;
              rs_cnt_d  = RS_LOAD;
            end
          end
        end else if (to_cnt == '0) begin
          hit_d     = 1'b0;
          state_nxt = S_RESULT;
          rs_cnt_d  = RS_LOAD;
        end else begin
          to_cnt_d = to_cnt - TO_W'(1);
        end
      end

      S_RESULT: begin
        if (rs_cnt == '0) begin
          if (round_num == LAST_ROUND) begin
            state_nxt = S_OVER;
          end else begin
            round_d   = round_num + RW'(1);
            state_nxt = S_DRAW;
          end
        end else begin
          rs_cnt_d = rs_cnt - RS_W'(1);
        end
      end

      S_OVER: begin
        if (start_edge) begin
          state_nxt = S_DRAW;
          score_d   = '0;
          round_d   = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Reload on entry so the fresh allowance is already visible during DRAW.
    if (state_nxt == S_DRAW) begin
      tries_d = TRIES_INIT;
`ifdef GUESS_HINT_EN
      hint_d  = 2'b00;
`endif
    end
  end

  // Pulse/flag outputs decode the next state so they line up with the
  // registered state they describe.
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      target      <= '0;
      tries_left  <= TRIES_INIT;
      score       <= '0;
      round_num   <= '0;
      to_cnt      <= '0;
      rs_cnt      <= '0;
      spin_seen   <= 1'b0;
      result_hit  <= 1'b0;
      rand_enable <= 1'b0;
      motor_start <= 1'b0;
      check       <= 1'b0;
      miss        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_q     <= start;
      target      <= target_d;
      tries_left  <= tries_d;
      score       <= score_d;
      round_num   <= round_d;
      to_cnt      <= to_cnt_d;
      rs_cnt      <= rs_cnt_d;
      spin_seen   <= spin_seen_d;
      result_hit  <= hit_d;
      rand_enable <= (state_nxt == S_DRAW);
      motor_start <= (state_nxt == S_LATCH);
      check       <= (state_nxt == S_RESULT) &&  hit_d;
      miss        <= (state_nxt == S_RESULT) && !hit_d;
      game_over   <= (state_nxt == S_OVER);
    end
  end

`ifdef GUESS_HINT_EN
  always_ff @(posedge clk) begin
    if (res) begin
      hint_q <= 2'b00;
    end else begin
      hint_q <= hint_d;
    end
  end

  assign hint = hint_q;
`else
  assign hint = 2'b00;
`endif

endmodule
